// File: rtl/reg_bank_pkg.sv
// Shared constants for the MIPS register file: geometry defaults and the
// architecturally special register indices.
package reg_bank_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

endpackage

// File: rtl/reg_bank_read_port.sv
// One combinational register-file read port: r0 forcing and, when built with
// REGFILE_BYPASS_EN, same-cycle forwarding of the WB write data.
module reg_read_port
  import reg_bank_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic [ADDR_W-1:0] i_index,
  input  logic [DATA_W-1:0] i_word,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_data
);

  logic index_is_zero;
  assign index_is_zero = (i_index == ADDR_W'(REG_ZERO));

`ifdef REGFILE_BYPASS_EN
  logic fwd_hit;
  // i_wr_en already excludes reset cycles; a nonzero read index implies a nonzero write index on a hit
  assign fwd_hit = i_wr_en && (i_wr_addr == i_index);

  always_comb begin
    o_data = '0;
    if (!index_is_zero) begin
      o_data = fwd_hit ? i_wr_data : i_word;
    end
  end
`else
  logic unused_wr_side;
  assign unused_wr_side = ^{i_wr_en, i_wr_addr, i_wr_data};

  always_comb begin
    o_data = '0;
    if (!index_is_zero) begin
      o_data = i_word;
    end
  end
`endif

endmodule

// File: rtl/reg_bank.sv
// 32x32 MIPS general-purpose register file with two ID read ports, a debug
// read port and commit bookkeeping. Optional write-through: REGFILE_BYPASS_EN.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_reg_write,
  input  logic [ADDR_W-1:0] i_write_register,
  input  logic [DATA_W-1:0] i_write_data,
  input  logic [ADDR_W-1:0] i_read_reg1,
  input  logic [ADDR_W-1:0] i_read_reg2,
  output logic [DATA_W-1:0] o_read_data1,
  output logic [DATA_W-1:0] o_read_data2,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data,
  output logic [CNT_W-1:0]  o_write_count,
  output logic [ADDR_W-1:0] o_last_write_reg
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [CNT_W-1:0]  write_count_q, write_count_d;
  logic [ADDR_W-1:0] last_write_reg_q, last_write_reg_d;

  logic wr_live;
  logic commit;

  // wr_live gates the forwarding path; commit additionally drops r0 writes
  assign wr_live = i_reg_write && !reset;
  assign commit  = wr_live && (i_write_register != ADDR_W'(REG_ZERO));

  always_comb begin
    regs_d           = regs_q;
    write_count_d    = write_count_q;
    last_write_reg_d = last_write_reg_q;
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_d[i] = '0;
      end
      write_count_d    = '0;
      last_write_reg_d = '0;
    end else if (commit) begin
      regs_d[i_write_register] = i_write_data;
      write_count_d            = write_count_q + CNT_W'(1);
      last_write_reg_d         = i_write_register;
    end
  end

  always_ff @(posedge clk) begin
    regs_q           <= regs_d;
    write_count_q    <= write_count_d;
    last_write_reg_q <= last_write_reg_d;
  end

  assign o_write_count    = write_count_q;
  assign o_last_write_reg = last_write_reg_q;

  reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
    .i_index   (i_read_reg1),
    .i_word    (regs_q[i_read_reg1]),
    .i_wr_en   (wr_live),
    .i_wr_addr (i_write_register),
    .i_wr_data (i_write_data),
    .o_data    (o_read_data1)
  );

  reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
    .i_index   (i_read_reg2),
    .i_word    (regs_q[i_read_reg2]),
    .i_wr_en   (wr_live),
    .i_wr_addr (i_write_register),
    .i_wr_data (i_write_data),
    .o_data    (o_read_data2)
  );

  reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dbg (
    .i_index   (i_dbg_addr),
    .i_word    (regs_q[i_dbg_addr]),
    .i_wr_en   (wr_live),
    .i_wr_addr (i_write_register),
    .i_wr_data (i_write_data),
    .o_data    (o_dbg_data)
  );

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: directed scenarios with literal expectations plus a
// randomized phase, all checked against an array model of the register file.
module tb_reg_bank;

  localparam int DW = 32;
  localparam int AW = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          i_reg_write;
  logic [AW-1:0] i_write_register, i_read_reg1, i_read_reg2, i_dbg_addr;
  logic [DW-1:0] i_write_data;

  logic [DW-1:0] rd1, rd2, dbg, w_rd1, w_rd2, w_dbg;
  logic [3:0]    cnt4;
  logic [31:0]   cnt32;
  logic [AW-1:0] last, w_last;

  // Narrow counter instance exercises the wrap; the wide one checks full-width counting.
  reg_bank #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(32), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset), .i_reg_write(i_reg_write),
    .i_write_register(i_write_register), .i_write_data(i_write_data),
    .i_read_reg1(i_read_reg1), .i_read_reg2(i_read_reg2),
    .o_read_data1(rd1), .o_read_data2(rd2),
    .i_dbg_addr(i_dbg_addr), .o_dbg_data(dbg),
    .o_write_count(cnt4), .o_last_write_reg(last)
  );

  reg_bank #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(32), .CNT_W(32)) u_dut_w (
    .clk(clk), .reset(reset), .i_reg_write(i_reg_write),
    .i_write_register(i_write_register), .i_write_data(i_write_data),
    .i_read_reg1(i_read_reg1), .i_read_reg2(i_read_reg2),
    .o_read_data1(w_rd1), .o_read_data2(w_rd2),
    .i_dbg_addr(i_dbg_addr), .o_dbg_data(w_dbg),
    .o_write_count(cnt32), .o_last_write_reg(w_last)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: plain array of architectural register contents.
  logic [31:0]   m_regs [32];
  logic [31:0]   m_cnt;
  logic [AW-1:0] m_last;
  bit            m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_cnt   = '0;
      m_last  = '0;
      m_valid = 1'b1;
    end else if (i_reg_write && i_write_register != 0) begin
      m_regs[i_write_register] = i_write_data;
      m_cnt  = m_cnt + 1;
      m_last = i_write_register;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [AW-1:0] idx);
    if (idx == 0) return '0;
    if (BYP && !reset && i_reg_write && i_write_register == idx) return i_write_data;
    return m_regs[idx];
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      check("rd1", rd1, exp_rd(i_read_reg1));
      check("rd2", rd2, exp_rd(i_read_reg2));
      check("dbg", dbg, exp_rd(i_dbg_addr));
      check("w_rd1", w_rd1, exp_rd(i_read_reg1));
      check("w_rd2", w_rd2, exp_rd(i_read_reg2));
      check("w_dbg", w_dbg, exp_rd(i_dbg_addr));
      check("cnt4", {28'd0, cnt4}, {28'd0, m_cnt[3:0]});
      check("cnt32", cnt32, m_cnt);
      check("last", {27'd0, last}, {27'd0, m_last});
      check("w_last", {27'd0, w_last}, {27'd0, m_last});
    end
  end

  task automatic drive(input logic rst, input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic [AW-1:0] r1,
                       input logic [AW-1:0] r2, input logic [AW-1:0] d);
    @(posedge clk);
    #1;
    reset = rst; i_reg_write = we; i_write_register = wa; i_write_data = wd;
    i_read_reg1 = r1; i_read_reg2 = r2; i_dbg_addr = d;
  endtask

  initial begin
    logic [AW-1:0] wa, r1, r2, d;
    logic [AW-1:0] final_dest;
    logic [DW-1:0] wd;
    logic          we, rst;

    reset = 1'b1; i_reg_write = 1'b1; i_write_register = 5'd5;
    i_write_data = 32'hDEAD_BEEF; i_read_reg1 = 5'd5; i_read_reg2 = 5'd5; i_dbg_addr = 5'd5;

    // Reset held two cycles while a write is presented
    drive(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd5);
    drive(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd5);
    #1;
    check("rst_rd1", rd1, 32'h0);
    check("rst_rd2", rd2, 32'h0);
    check("rst_dbg", dbg, 32'h0);
    check("rst_cnt", cnt32, 32'h0);
    check("rst_last", {27'd0, last}, 32'h0);

    // Basic commit
    drive(1'b0, 1'b1, 5'd7, 32'h1234_5678, 5'd0, 5'd0, 5'd0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 5'd7);
    #1;
    check("commit_rd1", rd1, 32'h1234_5678);
    check("commit_dbg", dbg, 32'h1234_5678);
    check("commit_cnt", cnt32, 32'd1);
    check("commit_last", {27'd0, last}, 32'd7);

    // Write to r0 is dropped and uncounted
    drive(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    #1;
    check("r0_same_rd1", rd1, 32'h0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    #1;
    check("r0_rd1", rd1, 32'h0);
    check("r0_rd2", rd2, 32'h0);
    check("r0_dbg", dbg, 32'h0);
    check("r0_cnt", cnt32, 32'd1);
    check("r0_last", {27'd0, last}, 32'd7);

    // Same-cycle read of the register being written
    drive(1'b0, 1'b1, 5'd31, 32'h0BAD_F00D, 5'd0, 5'd0, 5'd0);
    drive(1'b0, 1'b1, 5'd31, 32'hCAFE_0001, 5'd31, 5'd31, 5'd31);
    #1;
    check("byp_rd1", rd1, BYP ? 32'hCAFE_0001 : 32'h0BAD_F00D);
    check("byp_rd2", rd2, BYP ? 32'hCAFE_0001 : 32'h0BAD_F00D);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd31, 5'd31);
    #1;
    check("post_rd1", rd1, 32'hCAFE_0001);
    check("post_rd2", rd2, 32'hCAFE_0001);
    check("post_cnt", cnt32, 32'd3);

    // Fill r1..r31 with their index, then reset while writing r3
    for (int i = 1; i < 32; i++) drive(1'b0, 1'b1, AW'(i), 32'(i), 5'd0, 5'd0, 5'd0);
    drive(1'b1, 1'b1, 5'd3, 32'hAAAA_AAAA, 5'd17, 5'd3, 5'd30);
    #1;
    check("fill_rd1", rd1, 32'd17);
    check("fill_dbg", dbg, 32'd30);
    check("fill_cnt", cnt32, 32'd34);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      i_dbg_addr = AW'(i); i_read_reg1 = AW'(i); i_read_reg2 = AW'(31 - i);
      #1;
      check("clr_dbg", dbg, 32'h0);
      check("clr_rd1", rd1, 32'h0);
    end
    check("clr_cnt", cnt32, 32'h0);

    // Seventeen counted writes wrap the 4-bit counter to 1
    final_dest = '0;
    for (int i = 0; i < 17; i++) begin
      final_dest = AW'($urandom_range(1, 31));
      drive(1'b0, 1'b1, final_dest, $urandom, 5'd0, 5'd0, 5'd0);
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    #1;
    check("wrap_cnt4", {28'd0, cnt4}, 32'd1);
    check("wrap_cnt32", cnt32, 32'd17);
    check("wrap_last", {27'd0, last}, {27'd0, final_dest});

    // Randomized traffic, reads biased toward the write index
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      we  = ($urandom_range(0, 3) != 0);
      wa  = AW'($urandom_range(0, 31));
      wd  = $urandom;
      r1  = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 31));
      r2  = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 31));
      d   = ($urandom_range(0, 2) == 0) ? r1 : AW'($urandom_range(0, 31));
      drive(rst, we, wa, wd, r1, r2, d);
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
